ram4k_loader: RTL and testbench
===============================

// Module: ram4k_loader
// PURPOSE
//  Upstream write master for ram4k. Takes a stream of 16-bit words over a valid/ready
//  handshake and writes them to consecutive RAM addresses from a programmed base.
//  Drives ram4k's in/address/load pins directly. Used to boot-load program/data images
//  before the CPU is released. busy tells the top-level mux to give the RAM port to the loader.
// PARAMETERS
//  ADDR_W  12  RAM address width; addresses wrap modulo 2**ADDR_W
//  DATA_W  16  word width
// PORTS
//  clk         in   1       clock; all state updates on the rising edge
//  rst_n       in   1       asynchronous active-low reset
//  start       in   1       1-cycle pulse; sampled only in IDLE
//  base_addr   in   ADDR_W  first write address; captured on start
//  len_m1      in   ADDR_W  word count minus 1 (0 -> 1 word, 4095 -> 4096); captured on start
//  s_data      in   DATA_W  stream word
//  s_valid     in   1       s_data valid
//  s_ready     out  1       loader accepts s_data this cycle
//  ram_in      out  DATA_W  to ram4k in
//  ram_address out  ADDR_W  to ram4k address
//  ram_load    out  1       to ram4k load
//  ram_out     in   DATA_W  from ram4k out; read combinationally at ram_address (used only with verify)
//  busy        out  1       high in every state except IDLE
//  done        out  1       1-cycle pulse when the transfer completes
//  verify_err  out  1       sticky readback-mismatch flag (constant 0 without the macro)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; every output 0; address and word counters 0. An
//   assert mid-transfer aborts at once: ram_load drops asynchronously and nothing is resumed.
//  IDLE: s_ready=0. start=1 -> capture base_addr and len_m1, remaining=len_m1, go to WRITE.
//  WRITE: s_ready=1 while words remain to accept.
//   On handshake (s_valid&s_ready) register ram_in=s_data, ram_address=ptr, ram_load=1 for
//    the next cycle. ram4k commits at the edge that ends that cycle.
//   No handshake -> ram_load=0 next cycle; ram_address holds.
//   Throughput is 1 word per cycle. Write latency is 1 cycle from accept to the load presented.
//   ptr increments by 1 per accept and wraps 0xFFF -> 0x000 (ADDR_W-bit truncation).
//  Last word accepted (remaining==0): s_ready=0 the next cycle.
//   Then go to DONE, or to VERIFY if the macro is defined.
//  DONE: one cycle with done=1, ram_load=0, busy=1, then IDLE.
//  start is ignored whenever state != IDLE. s_valid outside WRITE is ignored (no accept).
//  s_data must hold while s_valid=1 && s_ready=0. The loader never drops an accepted word.
// CONFIGURATION
//  RAM4K_LOADER_VERIFY_EN defined:
//   - WRITE accumulates wsum = XOR of every accepted word.
//   - VERIFY state: ram_load=0; ram_address steps from base_addr over len_m1+1 addresses
//     (with wrap); rsum accumulates XOR of ram_out sampled each cycle.
//   - After the final address, verify_err |= (rsum != wsum); then DONE.
//   - verify_err clears only on reset or on start. Adds len_m1+1 cycles before done.
//  Undefined: no VERIFY state, no checksum logic, verify_err tied 0; ram_out is unused.
// STRUCTURE
//  Shared package/header ram4k_defs.vh: RAM_ADDR_W=12, RAM_DATA_W=16, and the loader state
//   encodings ST_IDLE=2'd0, ST_WRITE=2'd1, ST_VERIFY=2'd2, ST_DONE=2'd3.
//  One sub-module: xor_accum (DATA_W register with clear/enable), instantiated twice
//   (wsum, rsum) under the macro. All else in a single always block plus next-state logic.
// TESTING (bench instantiates ram4k_loader + ram4k; clk period 10)
//  1 base=0x000 len_m1=2, words ABAB,CDCD,1234 with s_valid held high -> ram_load high 3 cycles;
//    RAM[0..2] hold them; done 1 cycle after the last load; busy then 0.
//  2 base=0xFFE len_m1=3, words A,B,C,D -> RAM[FFE]=A, RAM[FFF]=B, RAM[000]=C, RAM[001]=D.
//  3 s_valid toggled 1,0,0,1 with len_m1=1 -> ram_load only in the cycles after each accept;
//    s_data changes while s_ready=0 are never written.
//  4 rst_n=0 after 2 of 5 words -> ram_load 0 immediately; outputs 0; RAM words 3-5 unwritten;
//    a new start after reset works.
//  5 start pulsed during WRITE -> ignored; transfer completes with the original base/len.
//  6 (VERIFY_EN) force a RAM word to change via hierarchical write before VERIFY ->
//    verify_err=1 after done; a clean rerun clears it on start and ends with 0.

Source files
------------

// File: rtl/ram4k_loader_pkg.sv
// Shared RAM geometry and loader state encoding for the ram4k boot loader.
package ram4k_loader_pkg;
    localparam int RAM_ADDR_W = 12;
    localparam int RAM_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } ld_state_e;
endpackage

// File: rtl/ram4k.sv
// 4K x 16 single-port RAM: write on rising edge when load_i, combinational read at address_i.
module ram4k
    import ram4k_loader_pkg::*;
(
    input  logic                  clk,
    input  logic [RAM_DATA_W-1:0] in_i,
    input  logic [RAM_ADDR_W-1:0] address_i,
    input  logic                  load_i,
    output logic [RAM_DATA_W-1:0] out_o
);
    logic [RAM_DATA_W-1:0] mem [0:(1<<RAM_ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (load_i) mem[address_i] <= in_i;
    end

    assign out_o = mem[address_i];
endmodule

// File: rtl/ram4k_loader_xor_accum.sv
// XOR checksum register with clear/enable; updates one cycle after enable, never stalls.
// Only built with RAM4K_LOADER_VERIFY_EN, where the loader keeps write and readback sums.
`ifdef RAM4K_LOADER_VERIFY_EN
module ram4k_loader_xor_accum #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] dat_i,
    output logic [W-1:0] sum_o
);
    logic [W-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr_i)     sum_d = '0;
        else if (en_i) sum_d = sum_q ^ dat_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sum_q <= '0;
        else        sum_q <= sum_d;
    end

    assign sum_o = sum_q;
endmodule
`endif

// File: rtl/ram4k_loader.sv
// Streams words into ram4k from a base address; 1 word/cycle, load presented 1 cycle after accept.
// s_ready drops once the last word is taken. RAM4K_LOADER_VERIFY_EN adds an XOR readback pass.
module ram4k_loader
    import ram4k_loader_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W-1:0] len_m1_i,
    input  logic [DATA_W-1:0] s_data_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    output logic [DATA_W-1:0] ram_in_o,
    output logic [ADDR_W-1:0] ram_address_o,
    output logic              ram_load_o,
    input  logic [DATA_W-1:0] ram_out_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              verify_err_o
);
    ld_state_e         state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              load_q, load_d;
    logic              last_q, last_d;
    logic              accept;

    // last_q marks "every word taken"; WRITE lingers one cycle so the final load lands before DONE
    assign s_ready_o = (state_q == ST_WRITE) && !last_q;
    assign accept    = s_valid_i && s_ready_o;

`ifdef RAM4K_LOADER_VERIFY_EN
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] vcnt_q, vcnt_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] wsum, rsum;
    logic              start_go;

    assign start_go = (state_q == ST_IDLE) && start_i;

    ram4k_loader_xor_accum #(.W(DATA_W)) u_wsum (
        .clk(clk), .rst_n(rst_n), .clr_i(start_go), .en_i(accept),
        .dat_i(s_data_i), .sum_o(wsum)
    );
    ram4k_loader_xor_accum #(.W(DATA_W)) u_rsum (
        .clk(clk), .rst_n(rst_n), .clr_i(start_go), .en_i(state_q == ST_VERIFY),
        .dat_i(ram_out_i), .sum_o(rsum)
    );
    assign verify_err_o = err_q;
`else
    logic unused_ram_out;
    assign unused_ram_out = ^ram_out_i;
    assign verify_err_o   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        addr_d  = addr_q;
        din_d   = din_q;
        load_d  = 1'b0;
        last_d  = last_q;
`ifdef RAM4K_LOADER_VERIFY_EN
        base_d  = base_q;
        len_d   = len_q;
        vcnt_d  = vcnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_WRITE;
                    ptr_d   = base_addr_i;
                    rem_d   = len_m1_i;
                    last_d  = 1'b0;
`ifdef RAM4K_LOADER_VERIFY_EN
                    base_d  = base_addr_i;
                    len_d   = len_m1_i;
                    err_d   = 1'b0;
`endif
                end
            end
            ST_WRITE: begin
                if (accept) begin
                    din_d  = s_data_i;
                    addr_d = ptr_q;
                    load_d = 1'b1;
                    ptr_d  = ptr_q + ADDR_W'(1);
                    if (rem_q == '0) last_d = 1'b1;
                    else             rem_d  = rem_q - ADDR_W'(1);
                end
                if (last_q) begin
`ifdef RAM4K_LOADER_VERIFY_EN
                    state_d = ST_VERIFY;
                    addr_d  = base_q;
                    vcnt_d  = '0;
`else
                    state_d = ST_DONE;
`endif
                end
            end
            ST_VERIFY: begin
`ifdef RAM4K_LOADER_VERIFY_EN
                addr_d = addr_q + ADDR_W'(1);
                vcnt_d = vcnt_q + ADDR_W'(1);
                // fold in the final read combinationally so the flag is valid during DONE
                if (vcnt_q == len_q) begin
                    err_d   = err_q | ((rsum ^ ram_out_i) != wsum);
                    state_d = ST_DONE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            load_q  <= 1'b0;
            last_q  <= 1'b0;
`ifdef RAM4K_LOADER_VERIFY_EN
            base_q  <= '0;
            len_q   <= '0;
            vcnt_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            load_q  <= load_d;
            last_q  <= last_d;
`ifdef RAM4K_LOADER_VERIFY_EN
            base_q  <= base_d;
            len_q   <= len_d;
            vcnt_q  <= vcnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign ram_in_o      = din_q;
    assign ram_address_o = addr_q;
    assign ram_load_o    = load_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = (state_q == ST_DONE);
endmodule

// File: tb/tb_ram4k_loader.sv
// Bench for ram4k_loader driving a real ram4k; a bench-side shadow memory is the reference image.
module tb_ram4k_loader;
    import ram4k_loader_pkg::*;

    localparam int DEPTH = 4096;
    localparam logic [15:0] CMASK = 16'h0100;
`ifdef RAM4K_LOADER_VERIFY_EN
    localparam int VEXTRA = 1;
`else
    localparam int VEXTRA = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [11:0] base_addr_i = '0;
    logic [11:0] len_m1_i = '0;
    logic [15:0] s_data_i = '0;
    logic        s_valid_i = 1'b0;
    logic        s_ready_o, ram_load_o, busy_o, done_o, verify_err_o;
    logic [15:0] ram_in_o, ram_out_w, ram_in_w;
    logic [11:0] ram_address_o;
    logic [15:0] corrupt = '0;

    int total = 0;
    int bad   = 0;
    logic [15:0] ref_mem [DEPTH];
    logic [15:0] wq [$];

    typedef struct {
        logic [11:0] base;
        logic [11:0] len;
        logic [7:0]  vpat;
        logic [63:0] words;
        int          exp_done;
        int          exp_last;
    } vec_t;
    vec_t tbl [5];

    always #5 clk = ~clk;

    // corrupt flips bits on the way into the RAM, standing in for a bad cell
    assign ram_in_w = ram_in_o ^ corrupt;

    ram4k_loader dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_addr_i(base_addr_i),
        .len_m1_i(len_m1_i), .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
        .ram_in_o(ram_in_o), .ram_address_o(ram_address_o), .ram_load_o(ram_load_o),
        .ram_out_i(ram_out_w), .busy_o(busy_o), .done_o(done_o), .verify_err_o(verify_err_o)
    );

    ram4k u_ram (
        .clk(clk), .in_i(ram_in_w), .address_i(ram_address_o), .load_i(ram_load_o), .out_o(ram_out_w)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_image(input string name);
        int nd = 0;
        int first = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (u_ram.mem[i] !== ref_mem[i]) begin
                nd++;
                if (first < 0) first = i;
            end
        end
        if (first >= 0)
            $display("  %s: first differing address %03h ram=%04h model=%04h",
                     name, first, u_ram.mem[first], ref_mem[first]);
        chk(name, nd, 0);
    endtask

    task automatic run_xfer(input logic [11:0] base, input logic [11:0] len, input logic [7:0] vpat,
                            input bit rnd, input bit glitch, input int cidx,
                            input int exp_done, input int exp_last, input string tag);
        int n, idx, c, last_acc, last_addr, perr;
        bit hs, hs_prev, got_done, v;
        logic [15:0] pd;
        logic [11:0] pa;
        n = int'(len) + 1;
        while (wq.size() < n) wq.push_back(16'($urandom));
        idx = 0; c = 0; last_acc = 0; last_addr = -1; perr = 0;
        hs_prev = 0; got_done = 0; pd = '0; pa = '0;
        @(negedge clk);
        start_i = 1'b1; base_addr_i = base; len_m1_i = len; s_valid_i = 1'b0;
        while (!got_done && c < 10000) begin
            @(negedge clk);
            c++;
            corrupt = '0;
            start_i = glitch && (c == 2);
            if (glitch && c == 2) begin
                base_addr_i = ~base;
                len_m1_i    = len + 12'd7;
            end
            if (c == 1) chk({tag, "_verr_clear_on_start"}, verify_err_o, 0);
            if (ram_load_o !== hs_prev) perr++;
            else if (hs_prev && (ram_in_o !== pd || ram_address_o !== pa)) perr++;
            if (s_ready_o !== (idx < n)) perr++;
            if (!done_o && busy_o !== 1'b1) perr++;
            if (perr == 1 && hs_prev !== 1'bx) begin
                $display("  %s: first protocol deviation at cycle %0d", tag, c);
                perr++;
            end
            if (done_o) begin
                got_done  = 1;
                s_valid_i = 1'b0;
                chk({tag, "_done_latency"}, c, last_acc + 2 + VEXTRA * n);
                if (exp_done >= 0) chk({tag, "_done_cycle"}, c, exp_done + VEXTRA * n);
                if (exp_last >= 0) chk({tag, "_last_addr"}, last_addr, exp_last);
                chk({tag, "_words_taken"}, idx, n);
                chk({tag, "_verify_err"}, verify_err_o,
                    (VEXTRA == 1 && cidx >= 0 && cidx < n) ? 1 : 0);
            end else begin
                v = (idx < n) && (rnd ? ($urandom_range(0, 3) != 0) : vpat[(c - 1) % 8]);
                s_valid_i = v;
                s_data_i  = v ? wq[idx] : 16'($urandom);
                hs = v && s_ready_o;
                if (hs) begin
                    pa = 12'(int'(base) + idx);
                    pd = wq[idx];
                    ref_mem[pa] = (idx == cidx) ? (pd ^ CMASK) : pd;
                    if (idx == cidx) corrupt = CMASK;
                    last_acc  = c;
                    last_addr = int'(pa);
                    idx++;
                end
                hs_prev = hs;
            end
        end
        corrupt = '0;
        chk({tag, "_done_seen"}, got_done, 1);
        chk({tag, "_protocol_errs"}, (perr > 1) ? perr - 1 : perr, 0);
        @(negedge clk);
        chk({tag, "_idle_after_done"}, {busy_o, done_o, s_ready_o, ram_load_o}, 0);
        check_image({tag, "_ram_image"});
        wq.delete();
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int perr;
        tbl[0] = '{12'h000, 12'd2, 8'hFF, 64'h0000_1234_CDCD_ABAB, 5, 32'h002};
        tbl[1] = '{12'hFFE, 12'd3, 8'hFF, 64'h000D_000C_000B_000A, 6, 32'h001};
        tbl[2] = '{12'h7F0, 12'd0, 8'hFF, 64'h0, 3, 32'h7F0};
        tbl[3] = '{12'hFFF, 12'd1, 8'hFF, 64'h0, 4, 32'h000};
        tbl[4] = '{12'h123, 12'd1, 8'h09, 64'h0, 6, 32'h124};

        #1;
        chk("reset_outputs", {s_ready_o, ram_load_o, busy_o, done_o, verify_err_o, ram_address_o, ram_in_o}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // full-depth load: 4096 words from 0, pointer wraps through FFF
        run_xfer(12'h000, 12'hFFF, 8'hFF, 0, 0, -1, 4098, 32'hFFF, "fill");

        perr = 0;
        s_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            s_data_i = 16'($urandom);
            if (ram_load_o !== 1'b0 || s_ready_o !== 1'b0 || busy_o !== 1'b0) perr++;
        end
        s_valid_i = 1'b0;
        chk("idle_valid_ignored", perr, 0);

        for (int i = 0; i < 5; i++) begin
            if (tbl[i].words != 0)
                for (int k = 0; k < 4; k++) wq.push_back(tbl[i].words[16*k +: 16]);
            run_xfer(tbl[i].base, tbl[i].len, tbl[i].vpat, 0, 0, -1,
                     tbl[i].exp_done, tbl[i].exp_last, $sformatf("vec%0d", i));
            if (i == 0) begin
                chk("vec0_ram0", u_ram.mem[0], 16'hABAB);
                chk("vec0_ram1", u_ram.mem[1], 16'hCDCD);
                chk("vec0_ram2", u_ram.mem[2], 16'h1234);
            end
            if (i == 1) begin
                chk("vec1_ramFFE", u_ram.mem[12'hFFE], 16'h000A);
                chk("vec1_ramFFF", u_ram.mem[12'hFFF], 16'h000B);
                chk("vec1_ram000", u_ram.mem[12'h000], 16'h000C);
                chk("vec1_ram001", u_ram.mem[12'h001], 16'h000D);
            end
        end

        // reset after two words have landed and a third is on the RAM port
        @(negedge clk);
        start_i = 1'b1; base_addr_i = 12'h300; len_m1_i = 12'd4;
        @(negedge clk);
        start_i = 1'b0; s_valid_i = 1'b1; s_data_i = 16'h5001;
        @(negedge clk);
        s_data_i = 16'h5002;
        @(negedge clk);
        s_data_i = 16'h5003;
        @(negedge clk);
        chk("abort_load_pending", ram_load_o, 1);
        rst_n = 1'b0;
        s_valid_i = 1'b0;
        #1;
        chk("abort_load_dropped", ram_load_o, 0);
        chk("abort_outputs_zero", {s_ready_o, busy_o, done_o, verify_err_o, ram_address_o, ram_in_o}, 0);
        ref_mem[12'h300] = 16'h5001;
        ref_mem[12'h301] = 16'h5002;
        @(negedge clk);
        @(negedge clk);
        check_image("abort_ram_image");
        rst_n = 1'b1;
        run_xfer(12'h300, 12'd4, 8'hFF, 0, 0, -1, 7, 32'h304, "after_rst");

        run_xfer(12'h400, 12'd5, 8'hFF, 0, 1, -1, 8, 32'h405, "start_glitch");

        for (int r = 0; r < 6; r++) begin
            logic [11:0] rb;
            logic [11:0] rl;
            rb = 12'($urandom);
            rl = 12'($urandom_range(0, 40));
            run_xfer(rb, rl, 8'hFF, 1, ($urandom_range(0, 1) == 1), -1, -1,
                     int'(12'(rb + rl)), $sformatf("rnd%0d", r));
        end

`ifdef RAM4K_LOADER_VERIFY_EN
        run_xfer(12'hFFC, 12'd5, 8'hFF, 0, 0, 2, 8, 32'h001, "verify_bad");
        chk("verify_err_sticky", verify_err_o, 1);
        run_xfer(12'h600, 12'd3, 8'hFF, 1, 0, -1, -1, 32'h603, "verify_clean");
        chk("verify_err_clean_end", verify_err_o, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
